sp_ram_burst_ctrl: RTL and testbench

- Initiator-side controller for a single-port synchronous RAM: drives the RAM's we/addr/din and consumes its registered dout.
- Turns one command (start address, beat count, direction) into a burst of RAM writes fed from a write stream, or RAM reads delivered on a read stream.
- Sits between a client (DMA/CPU bridge) and one RAM instance; handles RAM read latency and read-side backpressure.

---
 rtl/sp_ram_burst_ctrl_if.sv | 30 +++
 rtl/sp_ram_burst_ctrl.sv | 141 ++++++++++++++
 tb/tb_sp_ram_burst_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_burst_ctrl_if.sv
// Client-side bus of sp_ram_burst_ctrl: command, write stream, read stream and done.
// master = client (DMA/CPU bridge), slave = controller.
interface sp_ram_burst_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, done
  );
endinterface

// File: rtl/sp_ram_burst_ctrl.sv
// Burst controller for a single-port synchronous RAM (registered read data).
// Optional SP_RAM_BURST_BOUND_CHECK_EN adds an err output and rejects bursts running past the last address.
module sp_ram_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sp_ram_burst_ctrl_if.slave    bus,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef SP_RAM_BURST_BOUND_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WRITE  = 2'd1;
  localparam logic [1:0] S_READ   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]                 state_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [LEN_WIDTH-1:0]       cnt_q;
  logic [LEN_WIDTH-1:0]       pop_cnt_q;
  logic                       infl_q;
  logic [1:0][DATA_WIDTH-1:0] fifo_q;
  logic                       wptr_q;
  logic                       rptr_q;
  logic [1:0]                 fcnt_q;
  logic                       err_q;

  logic       cmd_fire;
  logic       cmd_zero;
  logic       bound_err;
  logic       rd_start;
  logic       wr_beat;
  logic       pop;
  logic       issue;
  logic [1:0] occ;

`ifdef SP_RAM_BURST_BOUND_CHECK_EN
  localparam int SUM_W = ADDR_WIDTH + LEN_WIDTH + 1;
  logic [SUM_W-1:0] span;
  assign span      = SUM_W'(bus.cmd_addr) + SUM_W'(bus.cmd_len);
  assign bound_err = span > (SUM_W'(1) << ADDR_WIDTH);
  assign err       = (state_q == S_FINISH) & err_q & ~rst;
`else
  assign bound_err = 1'b0;
`endif

  assign cmd_fire = (state_q == S_IDLE) & bus.cmd_valid & ~rst;
  assign cmd_zero = (bus.cmd_len == '0);
  // The first read is issued in the accept cycle so data reaches the FIFO two cycles after accept.
  assign rd_start = cmd_fire & ~bus.cmd_write & ~cmd_zero & ~bound_err;
  assign wr_beat  = (state_q == S_WRITE) & bus.wr_valid & ~rst;
  assign pop      = (fcnt_q != 2'd0) & bus.rd_ready & ~rst;

  // Occupancy counts the slot freed by this cycle's pop, sustaining one beat per cycle.
  assign occ   = fcnt_q + 2'(infl_q) - 2'(pop);
  assign issue = (state_q == S_READ) & (cnt_q != '0) & (occ < 2'd2);

  assign bus.cmd_ready = (state_q == S_IDLE) & ~rst;
  assign bus.wr_ready  = (state_q == S_WRITE) & ~rst;
  assign bus.rd_valid  = (fcnt_q != 2'd0) & ~rst;
  assign bus.rd_data   = fifo_q[rptr_q];
  assign bus.done      = (state_q == S_FINISH) & ~rst;

  assign ram_we   = wr_beat;
  assign ram_din  = wr_beat ? bus.wr_data : '0;
  assign ram_addr = rst ? '0 : (rd_start ? bus.cmd_addr : addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      pop_cnt_q <= '0;
      infl_q    <= 1'b0;
      fifo_q    <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      fcnt_q    <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      infl_q <= rd_start | issue;
      if (infl_q) begin
        fifo_q[wptr_q] <= ram_dout;
        wptr_q         <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      fcnt_q <= fcnt_q + 2'(infl_q) - 2'(pop);

      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            err_q <= bound_err;
            if (cmd_zero || bound_err) begin
              state_q <= S_FINISH;
            end else if (bus.cmd_write) begin
              addr_q  <= bus.cmd_addr;
              cnt_q   <= bus.cmd_len;
              state_q <= S_WRITE;
            end else begin
              addr_q    <= bus.cmd_addr + ADDR_WIDTH'(1);
              cnt_q     <= bus.cmd_len - LEN_WIDTH'(1);
              pop_cnt_q <= bus.cmd_len;
              state_q   <= S_READ;
            end
          end
        end
        S_WRITE: begin
          if (wr_beat) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            cnt_q  <= cnt_q - LEN_WIDTH'(1);
            if (cnt_q == LEN_WIDTH'(1)) state_q <= S_FINISH;
          end
        end
        S_READ: begin
          if (issue) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            cnt_q  <= cnt_q - LEN_WIDTH'(1);
          end
          if (pop) begin
            pop_cnt_q <= pop_cnt_q - LEN_WIDTH'(1);
            if (pop_cnt_q == LEN_WIDTH'(1) && cnt_q == '0) state_q <= S_FINISH;
          end
        end
        default: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_burst_ctrl.sv
// Self-checking bench for sp_ram_burst_ctrl: reference memory model, expected write/read queues,
// per-cycle compare process plus directed timing checks (SP_RAM_BURST_BOUND_CHECK_EN aware).
module tb_sp_ram_burst_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [7:0] mem [16];
`ifdef SP_RAM_BURST_BOUND_CHECK_EN
  logic       err;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  logic [7:0]  ref_mem [16];
  logic [11:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = '0;
  logic [7:0]  fd;

  sp_ram_burst_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(5)) bus ();

  sp_ram_burst_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
`ifdef SP_RAM_BURST_BOUND_CHECK_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit oob(int a, int l);
`ifdef SP_RAM_BURST_BOUND_CHECK_EN
    return (a + l) > 16;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (ram_we) begin
        if (exp_wr.size() == 0) chk("ram_we_unexpected", ram_we, 1'b0);
        else begin
          logic [11:0] w;
          w = exp_wr.pop_front();
          chk("ram_addr", ram_addr, w[11:8]);
          chk("ram_din", ram_din, w[7:0]);
        end
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", bus.rd_valid, 1'b0);
        else chk("rd_data", bus.rd_data, exp_rd.pop_front());
      end
      if (prev_stall) begin
        chk("rd_hold_valid", bus.rd_valid, 1'b1);
        chk("rd_hold_data", bus.rd_data, prev_data);
      end
      prev_stall = bus.rd_valid && !bus.rd_ready;
      prev_data  = bus.rd_data;
      if (bus.done) done_cnt++;
`ifdef SP_RAM_BURST_BOUND_CHECK_EN
      if (!bus.done) chk("err_idle", err, 1'b0);
`endif
    end
  end

  task automatic send_cmd(input bit w, input int a, input int l);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = 4'(a);
    bus.cmd_len   = 5'(l);
    @(negedge clk);
    while (!bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) chk("cmd_accept_timeout", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_write(input int a, input int l, input logic [7:0] d0);
    bit e;
    int k = 0, t = 0, dc;
    e  = oob(a, l);
    dc = done_cnt;
    if (!e) for (int i = 0; i < l; i++) begin
      exp_wr.push_back({4'((a + i) % 16), 8'(d0 + 8'(i))});
      ref_mem[(a + i) % 16] = 8'(d0 + 8'(i));
    end
    send_cmd(1'b1, a, l);
    if (!e && l != 0) begin
      while (k < l && t < 100) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'(d0 + 8'(k));
        @(negedge clk);
        if (bus.wr_ready) k++;
        @(posedge clk); #1;
        t++;
      end
      chk("wr_beats", k, l);
      chk("wr_cycles", t, l);
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_done", bus.done, 1'b1);
    chk("wr_ready_at_done", bus.wr_ready, 1'b0);
`ifdef SP_RAM_BURST_BOUND_CHECK_EN
    chk("wr_err", err, e);
`endif
    @(negedge clk);
    chk("wr_done_low", bus.done, 1'b0);
    chk("wr_idle_ready", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    chk("wr_done_once", done_cnt, dc + 1);
    chk("wr_queue_drained", exp_wr.size(), 0);
  endtask

  task automatic do_read(input int a, input int l, input int mode, input int abort,
                         output logic [7:0] first_data);
    bit e;
    int pops = 0, t = 1, first = -1, dc;
    e  = oob(a, l);
    dc = done_cnt;
    first_data = '0;
    if (!e) for (int i = 0; i < l; i++) exp_rd.push_back(ref_mem[(a + i) % 16]);
    send_cmd(1'b0, a, l);
    if (!e && l != 0) begin
      while (pops < l && t < 200 && !(abort != 0 && pops == abort)) begin
        bus.rd_ready = (mode == 0) ? 1'b1 : (t % 3 == 2);
        @(negedge clk);
        if (bus.rd_valid && first < 0) first = t;
        if (bus.rd_valid && bus.rd_ready) begin
          if (pops == 0) first_data = bus.rd_data;
          pops++;
        end
        @(posedge clk); #1;
        t++;
      end
      if (abort == 0) chk("rd_beats", pops, l);
    end
    bus.rd_ready = 1'b0;
    if (abort != 0) return;
    @(negedge clk);
    chk("rd_done", bus.done, 1'b1);
    chk("rd_valid_at_done", bus.rd_valid, 1'b0);
`ifdef SP_RAM_BURST_BOUND_CHECK_EN
    chk("rd_err", err, e);
`endif
    if (mode == 0 && !e && l != 0) begin
      chk("rd_first_latency", first, 2);
      chk("rd_done_cycle", t, l + 2);
    end
    @(negedge clk);
    chk("rd_done_low", bus.done, 1'b0);
    chk("rd_idle_ready", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    chk("rd_done_once", done_cnt, dc + 1);
    chk("rd_queue_drained", exp_rd.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int dc;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 4'h0);
    chk("rst_ram_din", ram_din, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;

    // Basic write then readback with ready held high
    do_write(2, 3, 8'hA1);
    do_read(2, 3, 0, 0, fd);
    chk("rd_first_lit", fd, 8'hA1);

    // Stalled read, ready pattern 1,0,0,1,...
    do_write(5, 1, 8'hB5);
    do_read(2, 4, 1, 0, fd);
    chk("rd_stall_first_lit", fd, 8'hA1);

    // Address wrap (rejected instead when bound checking is built in)
    do_write(14, 4, 8'h10);
`ifndef SP_RAM_BURST_BOUND_CHECK_EN
    chk("wrap_mem15_lit", mem[15], 8'h11);
    chk("wrap_mem0_lit", mem[0], 8'h12);
    chk("wrap_mem1_lit", mem[1], 8'h13);
`endif
    do_read(14, 4, 0, 0, fd);

    // Zero-length commands
    do_write(7, 0, 8'h00);
    do_read(7, 0, 0, 0, fd);

    // Reset in the middle of a read burst
    do_write(0, 6, 8'h30);
    dc = done_cnt;
    do_read(0, 6, 0, 2, fd);
    exp_rd.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rd_valid", bus.rd_valid, 1'b0);
    chk("midrst_ram_we", ram_we, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_cmd_ready", bus.cmd_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_rd_valid_2", bus.rd_valid, 1'b0);
    chk("midrst_done_2", bus.done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready_after", bus.cmd_ready, 1'b1);
    chk("midrst_rd_valid_after", bus.rd_valid, 1'b0);
    chk("midrst_no_done", done_cnt, dc);
    @(posedge clk); #1;
    do_read(0, 6, 0, 0, fd);
    chk("post_rst_first_lit", fd, 8'h30);

`ifdef SP_RAM_BURST_BOUND_CHECK_EN
    // Out-of-range burst is accepted, errors out, touches nothing
    do_write(12, 5, 8'h40);
    do_read(12, 5, 0, 0, fd);
    do_write(12, 4, 8'h50);
    chk("bound_mem15_lit", mem[15], 8'h53);
    do_read(12, 4, 0, 0, fd);
    chk("bound_first_lit", fd, 8'h50);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
